// File: rtl/p23_timer_counter.sv
// Prescaled up/down timer/counter channel with terminal-count modes,
// compare-match pulse and a sticky interrupt flag.
module p23_timer_counter #(
  parameter int               WIDTH       = 32,
  parameter int               PRESC_WIDTH = 8,
  parameter logic [WIDTH-1:0] PRESET      = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_value,
  input  logic                   dir,
  input  logic [1:0]             mode,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic [WIDTH-1:0]       cmp_value,
  input  logic                   irq_clr,
  output logic [WIDTH-1:0]       q,
  output logic                   tc,
  output logic                   cmp_match,
  output logic                   irq,
  output logic                   running
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RELOAD  = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0]       ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_WIDTH-1:0] PONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

  mode_e                  mode_s;
  logic [PRESC_WIDTH-1:0] pcnt, pcnt_n;
  logic [WIDTH-1:0]       q_n;
  logic                   stopped, stopped_n;
  logic                   tc_n, cmp_n, irq_n;
  logic                   tick, at_term, hold;

  assign mode_s  = mode_e'(mode);
  assign running = en & ~stopped;

  always_comb begin
    q_n       = q;
    pcnt_n    = pcnt;
    stopped_n = stopped;
    tc_n      = 1'b0;
    cmp_n     = 1'b0;
    tick      = running & (pcnt >= presc);
    at_term   = dir ? (q == '1) : (q == '0);
    // saturate/one-shot at terminal keep q, which must not re-fire a compare match
    hold      = at_term & ((mode_s == MODE_SAT) | (mode_s == MODE_ONESHOT));

    if (load) begin
      q_n       = load_value;
      pcnt_n    = '0;
      stopped_n = 1'b0;
      cmp_n     = (load_value == cmp_value);
    end else if (tick) begin
      pcnt_n = '0;
      if (at_term) begin
        tc_n = 1'b1;
        case (mode_s)
          MODE_WRAP:    q_n = dir ? '0 : '1;
          MODE_SAT:     q_n = q;
          MODE_ONESHOT: stopped_n = 1'b1;
          MODE_RELOAD:  q_n = load_value;
          default:      q_n = q;
        endcase
      end else begin
        q_n = dir ? (q + ONE) : (q - ONE);
      end
      cmp_n = ~hold & (q_n == cmp_value);
    end else if (running) begin
      pcnt_n = pcnt + PONE;
    end

    irq_n = tc_n | cmp_n | (irq & ~irq_clr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q         <= PRESET;
      pcnt      <= '0;
      stopped   <= 1'b0;
      tc        <= 1'b0;
      cmp_match <= 1'b0;
      irq       <= 1'b0;
    end else begin
      q         <= q_n;
      pcnt      <= pcnt_n;
      stopped   <= stopped_n;
      tc        <= tc_n;
      cmp_match <= cmp_n;
      irq       <= irq_n;
    end
  end

endmodule

// File: tb/tb_p23_timer_counter.sv
// Table-driven, scoreboarded bench for p23_timer_counter (WIDTH=8, PRESET=5).
module tb_p23_timer_counter;

  localparam int W  = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          en, load, dir, irq_clr;
  logic [W-1:0]  load_value, cmp_value;
  logic [1:0]    mode;
  logic [PW-1:0] presc;
  logic [W-1:0]  q;
  logic          tc, cmp_match, irq, running;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         en, load, dir, clr;
    logic [1:0]   mode;
    logic [W-1:0] lv, presc, cmp;
    logic [W-1:0] q;
    logic         tc, cm, irq, run;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  p23_timer_counter #(.WIDTH(W), .PRESC_WIDTH(PW), .PRESET(8'd5)) dut (
    .clk(clk), .resetn(resetn), .en(en), .load(load), .load_value(load_value),
    .dir(dir), .mode(mode), .presc(presc), .cmp_value(cmp_value),
    .irq_clr(irq_clr), .q(q), .tc(tc), .cmp_match(cmp_match), .irq(irq),
    .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(input logic e, input logic ld, input logic [7:0] lv,
                              input logic d, input logic [1:0] m, input logic [7:0] p,
                              input logic [7:0] c, input logic clr, input logic [7:0] eq,
                              input logic etc, input logic ecm, input logic eirq,
                              input logic erun);
    vec_t v;
    v.en = e; v.load = ld; v.lv = lv; v.dir = d; v.mode = m; v.presc = p;
    v.cmp = c; v.clr = clr; v.q = eq; v.tc = etc; v.cm = ecm; v.irq = eirq;
    v.run = erun;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s (row %0d): actual=%0h required=%0h", name, row, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    en = v.en; load = v.load; load_value = v.lv; dir = v.dir; mode = v.mode;
    presc = v.presc; cmp_value = v.cmp; irq_clr = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int row);
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty (row %0d): actual=0 required=1", row);
    end else begin
      e = sb.pop_front();
      chk("q", row, q, e.q);
      chk("tc", row, {7'd0, tc}, {7'd0, e.tc});
      chk("cmp_match", row, {7'd0, cmp_match}, {7'd0, e.cm});
      chk("irq", row, {7'd0, irq}, {7'd0, e.irq});
      chk("running", row, {7'd0, running}, {7'd0, e.run});
    end
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; load = 1'b0; dir = 1'b1; irq_clr = 1'b0;
    load_value = '0; cmp_value = 8'hAA; mode = 2'd0; presc = '0;

    // prescale by 4 from PRESET, then up-wrap
    for (int i = 1; i <= 12; i++)
      vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'd3, 8'hAA, 0, 8'(5 + i / 4), 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8'hFE, 1, 0, 0, 8'hAA, 0, 8'hFE, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'hFE, 1, 0, 0, 8'hAA, 0, 8'hFF, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'hFE, 1, 0, 0, 8'hAA, 0, 8'h00, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'hFE, 1, 0, 0, 8'hAA, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 8'hFE, 1, 0, 0, 8'hAA, 1, 8'h00, 0, 0, 0, 0));
    // saturate down with compare at 0: single match, repeated tc
    vecs.push_back(mk(1, 1, 8'h02, 0, 1, 0, 8'h00, 0, 8'h02, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h02, 0, 1, 0, 8'h00, 0, 8'h01, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h02, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 8'h02, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1));
    vecs.push_back(mk(1, 0, 8'h02, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'h02, 0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0));
    // one-shot, then restart by load
    vecs.push_back(mk(1, 1, 8'hFD, 1, 2, 0, 8'hAA, 0, 8'hFD, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'hFD, 1, 2, 0, 8'hAA, 0, 8'hFE, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'hFD, 1, 2, 0, 8'hAA, 0, 8'hFF, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'hFD, 1, 2, 0, 8'hAA, 0, 8'hFF, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'hFD, 1, 2, 0, 8'hAA, 0, 8'hFF, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'hFD, 1, 2, 0, 8'hAA, 1, 8'hFF, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h10, 1, 2, 0, 8'hAA, 0, 8'h10, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h10, 1, 2, 0, 8'hAA, 0, 8'h11, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h10, 1, 2, 0, 8'hAA, 0, 8'h11, 0, 0, 0, 0));
    // auto-reload with compare on the reload value; irq set beats irq_clr
    vecs.push_back(mk(0, 1, 8'hFF, 1, 3, 0, 8'hF0, 0, 8'hFF, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'hF0, 1, 3, 0, 8'hF0, 1, 8'hF0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 8'hF0, 1, 3, 0, 8'hF0, 0, 8'hF1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'hF0, 1, 3, 0, 8'hF0, 1, 8'hF1, 0, 0, 0, 0));
    // load beats a due tick, then presc lowered below pcnt, then down-wrap
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 2, 8'hAA, 0, 8'hF1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 2, 8'hAA, 0, 8'hF1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8'h30, 1, 0, 2, 8'hAA, 0, 8'h30, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h30, 1, 0, 2, 8'hAA, 0, 8'h30, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h30, 1, 0, 2, 8'hAA, 0, 8'h30, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h30, 1, 0, 2, 8'hAA, 0, 8'h31, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h30, 1, 0, 5, 8'hAA, 0, 8'h31, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h30, 1, 0, 5, 8'hAA, 0, 8'h31, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h30, 1, 0, 1, 8'hAA, 0, 8'h32, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h30, 1, 0, 1, 8'hAA, 0, 8'h32, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h30, 1, 0, 1, 8'hAA, 0, 8'h33, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 1, 8'hAA, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 1, 8'hAA, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 1, 8'hAA, 0, 8'hFF, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'hAA, 1, 8'hFF, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", -1, q, 8'h05);
    chk("reset_tc", -1, {7'd0, tc}, 8'h00);
    chk("reset_cmp", -1, {7'd0, cmp_match}, 8'h00);
    chk("reset_irq", -1, {7'd0, irq}, 8'h00);
    chk("reset_running", -1, {7'd0, running}, 8'h00);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // asynchronous reset between edges while irq and tc are set
    applyStimulus(mk(1, 1, 8'hFF, 1, 0, 0, 8'hAA, 0, 8'hFF, 0, 0, 0, 1));
    checkOutput(1000);
    applyStimulus(mk(1, 0, 8'hFF, 1, 0, 0, 8'hAA, 0, 8'h00, 1, 0, 1, 1));
    checkOutput(1001);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_q", 1002, q, 8'h05);
    chk("async_irq", 1002, {7'd0, irq}, 8'h00);
    chk("async_tc", 1002, {7'd0, tc}, 8'h00);
    chk("async_running", 1002, {7'd0, running}, 8'h01);
    @(negedge clk);
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
